// File: rtl/adc_deser_pkg.sv
// adc_deser_pkg: shared state encoding, default frame geometry and nominal divider ratios.
package adc_deser_pkg;
    typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;
    localparam int NCH_DEF   = 4;
    localparam int BITS_DEF  = 8;
    localparam int FDATA_DIV = 12;
    localparam int FRAME_DIV = 8;
endpackage

// File: rtl/edge_det_sync.sv
// edge_det_sync: registered rising-edge detector for a clock-synchronous level.
module edge_det_sync
    import adc_deser_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) d_q <= 1'b0;
        else d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/adc_frame_deser.sv
// adc_frame_deser: frames serial ADC lines into per-channel words with a valid/ready holding register.
// Optional ADC_DESER_FRAME_CNT_EN adds a 16-bit closed-frame counter latched with each word.
module adc_frame_deser
    import adc_deser_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int BITS  = BITS_DEF,
    parameter int CNT_W = 4
) (
    input  logic                 CLK_G,
    input  logic                 RST_N,
    input  logic                 SPI_EN,
    input  logic                 FDATA,
    input  logic                 FADC,
    input  logic [NCH-1:0]       ADC_DOUT,
    output logic [NCH*BITS-1:0]  DATA_OUT,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
`ifdef ADC_DESER_FRAME_CNT_EN
    ,
    output logic [15:0]          FRAME_CNT
`endif
);
    state_t                   state;
    logic                     fdata_rise, fadc_rise, full_cnt, good, load;
    logic [NCH-1:0][BITS-1:0] shift, shifted;
    logic [CNT_W-1:0]         count;
`ifdef ADC_DESER_FRAME_CNT_EN
    logic [15:0]              frame_cnt;
`endif

    edge_det_sync u_fdata (.clk(CLK_G), .rst_n(RST_N), .clr(SPI_EN), .d(FDATA), .rise(fdata_rise));
    edge_det_sync u_fadc  (.clk(CLK_G), .rst_n(RST_N), .clr(SPI_EN), .d(FADC),  .rise(fadc_rise));

    for (genvar c = 0; c < NCH; c++) begin : g_shift
        assign shifted[c] = {shift[c][BITS-2:0], ADC_DOUT[c]};
    end

    assign full_cnt = count == CNT_W'(BITS);
    assign good     = !SPI_EN && state == RUN && fadc_rise && full_cnt;
    // A same-cycle handshake frees the holding register for the new word.
    assign load     = good && (!DATA_VALID || DATA_READY);

    always_ff @(posedge CLK_G) begin
        if (!RST_N) begin
            state      <= IDLE;
            shift      <= '0;
            count      <= '0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
`ifdef ADC_DESER_FRAME_CNT_EN
            frame_cnt  <= '0;
            FRAME_CNT  <= '0;
`endif
        end else begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            if (load) begin
                DATA_OUT   <= shift;
                DATA_VALID <= 1'b1;
`ifdef ADC_DESER_FRAME_CNT_EN
                FRAME_CNT  <= frame_cnt + 16'd1;
`endif
            end else if (DATA_VALID && DATA_READY) begin
                DATA_VALID <= 1'b0;
            end
            if (SPI_EN) begin
                state <= IDLE;
                shift <= '0;
                count <= '0;
`ifdef ADC_DESER_FRAME_CNT_EN
                frame_cnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE: state <= ALIGN;
                    ALIGN: if (fadc_rise) begin
                        state <= RUN;
                        count <= CNT_W'(fdata_rise);
                        if (fdata_rise) shift <= shifted;
                    end
                    RUN: begin
                        if (fadc_rise) begin
                            FRAME_ERR <= !full_cnt;
                            OVERRUN   <= full_cnt && !load;
                            count     <= CNT_W'(fdata_rise);
`ifdef ADC_DESER_FRAME_CNT_EN
                            frame_cnt <= frame_cnt + 16'd1;
`endif
                        end else if (fdata_rise) begin
                            count <= (&count) ? count : count + 1'b1;
                        end
                        if (fdata_rise) shift <= shifted;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_deser.sv
// tb_adc_frame_deser: drives framed serial streams and checks delivered words, error and overrun pulses
// against a frame-level queue model; define ADC_DESER_FRAME_CNT_EN to also check FRAME_CNT.
module tb_adc_frame_deser;
    import adc_deser_pkg::*;
    localparam int NCH = NCH_DEF;
    localparam int BITS = BITS_DEF;
    localparam int W = NCH * BITS;

    logic CLK_G = 1'b0, RST_N = 1'b0, SPI_EN = 1'b0, FDATA = 1'b0, FADC = 1'b0, DATA_READY = 1'b1;
    logic [NCH-1:0] ADC_DOUT = '0;
    logic [W-1:0] DATA_OUT;
    logic DATA_VALID, FRAME_ERR, OVERRUN;
`ifdef ADC_DESER_FRAME_CNT_EN
    logic [15:0] FRAME_CNT;
`endif

    adc_frame_deser dut (
        .CLK_G(CLK_G), .RST_N(RST_N), .SPI_EN(SPI_EN), .FDATA(FDATA), .FADC(FADC),
        .ADC_DOUT(ADC_DOUT), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
`ifdef ADC_DESER_FRAME_CNT_EN
        , .FRAME_CNT(FRAME_CNT)
`endif
    );

    always #5 CLK_G = ~CLK_G;

    int compared = 0, mismatched = 0;
    int n_err = 0, n_ovr = 0, exp_err = 0, exp_ovr = 0, n_closed = 0, open_bits = 0;
    logic [W-1:0] q_data[$];
    int q_cnt[$];
    logic [W-1:0] open_w = '0, held = '0;
    bit aligned = 0, rand_ready = 0, hold_chk = 0, expect_valid = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_outputs();
        if (rand_ready) DATA_READY = 1'($urandom_range(0, 1));
        if (expect_valid) chk("valid_latency", DATA_VALID, 1);
        expect_valid = 0;
        if (hold_chk) chk("data_hold", DATA_OUT, held);
        if (DATA_VALID && DATA_READY) begin
            chk("word_expected", q_data.size() > 0, 1);
            if (q_data.size() > 0) begin
                chk("data_out", DATA_OUT, q_data.pop_front());
`ifdef ADC_DESER_FRAME_CNT_EN
                chk("frame_cnt", FRAME_CNT, q_cnt.pop_front());
`else
                void'(q_cnt.pop_front());
`endif
            end
        end
        hold_chk = DATA_VALID && !DATA_READY;
        held = DATA_OUT;
        n_err += int'(FRAME_ERR);
        n_ovr += int'(OVERRUN);
    endtask

    // An FADC rise closes the open frame: deliver it, count an overrun, or count a frame error.
    task automatic model_close();
        if (aligned) begin
            n_closed++;
            if (open_bits == BITS) begin
                if (q_data.size() == 0) begin
                    q_data.push_back(open_w);
                    q_cnt.push_back(n_closed & 16'hFFFF);
                    expect_valid = 1;
                end else exp_ovr++;
            end else exp_err++;
        end
        aligned = 1;
    endtask

    task automatic tick(input bit close = 0);
        check_outputs();
        if (close) model_close();
        @(negedge CLK_G);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [W-1:0] w, input int nbits);
        int periods = (nbits > BITS) ? nbits : BITS;
        for (int p = 0; p < periods; p++) begin
            for (int k = 0; k < FDATA_DIV; k++) begin
                FADC = p < FRAME_DIV / 2;
                FDATA = k < FDATA_DIV / 2 && p < nbits;
                if (k == 0)
                    for (int c = 0; c < NCH; c++)
                        ADC_DOUT[c] = (p < BITS) ? w[c*BITS + BITS-1-p] : 1'($urandom);
                tick(p == 0 && k == 0);
            end
        end
        open_w = w;
        open_bits = nbits;
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    task automatic check_counts(input string tag);
        chk({tag, "_frame_err"}, n_err, exp_err);
        chk({tag, "_overrun"}, n_ovr, exp_ovr);
    endtask

    initial begin
        @(negedge CLK_G);
        idle(3);
        chk("rst_data_out", DATA_OUT, 0);
        chk("rst_data_valid", DATA_VALID, 0);
        chk("rst_frame_err", FRAME_ERR, 0);
        chk("rst_overrun", OVERRUN, 0);

        // Release reset in the middle of a frame: these bits precede the first FADC rise.
        RST_N = 1'b1;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < FDATA_DIV; k++) begin
                FADC = 1'b0;
                FDATA = k < FDATA_DIV / 2;
                ADC_DOUT = NCH'($urandom);
                tick();
            end
        chk("no_valid_before_align", DATA_VALID, 0);

        send_frame(32'h01FF3CA5, 8);
        send_frame(rnd(), 8);
        chk("nominal_pending", q_data.size(), 0);
        send_frame(rnd(), 8);
        send_frame(rnd(), 8);
        check_counts("nominal");

        send_frame(rnd(), 7);
        send_frame(rnd(), 8);
        send_frame(rnd(), 20);
        send_frame(rnd(), 9);
        send_frame(rnd(), 8);
        send_frame(rnd(), 8);
        check_counts("short_long");
        chk("err_count_seen", n_err, 3);

        DATA_READY = 1'b0;
        send_frame(rnd(), 8);
        send_frame(rnd(), 8);
        idle(5);
        chk("bp_held_valid", DATA_VALID, 1);
        check_counts("backpressure");
        DATA_READY = 1'b1;
        tick();
        chk("bp_valid_drop", DATA_VALID, 0);

        DATA_READY = 1'b0;
        send_frame(rnd(), 8);
        send_frame(rnd(), 4);
        SPI_EN = 1'b1;
        FDATA = 1'b0;
        FADC = 1'b0;
        aligned = 0;
        n_closed = 0;
        idle(20);
        DATA_READY = 1'b1;
        idle(30);
        SPI_EN = 1'b0;
        chk("spi_drained", q_data.size(), 0);
        chk("spi_valid_low", DATA_VALID, 0);
        idle(4);
        send_frame(rnd(), 8);
        send_frame(rnd(), 7);
        send_frame(rnd(), 8);
        send_frame(rnd(), 8);
        check_counts("spi");

        rand_ready = 1;
        for (int i = 0; i < 12; i++) begin
            int sel = $urandom_range(0, 5);
            send_frame(rnd(), sel == 0 ? 7 : sel == 1 ? 9 : 8);
        end
        rand_ready = 0;
        DATA_READY = 1'b1;
        send_frame(rnd(), 8);
        idle(20);
        chk("final_drained", q_data.size(), 0);
        check_counts("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/adc_frame_deser.md
Name: adc_frame_deser

Overview:
- Receive-side counterpart of the clock generator. Samples the serial ADC data lines on each FDATA rising edge and frames them on FADC rising edges.
- Assembles one BITS-wide word per channel per ADC conversion and hands the words to the CIC/decimation path with a valid/ready handshake.
- Runs entirely in the CLK_G domain. FDATA and FADC arrive as CLK_G-synchronous levels (1-FF-delayed divider outputs), so edges are detected by registered compare.

Parameters:
- NCH, 4, number of serial ADC data lines (one per channel)
- BITS, 8, bits per channel per frame (FDATA edges per FADC period)
- CNT_W, 4, width of the bit counter; must satisfy 2^CNT_W > BITS

Ports:
- CLK_G  in  1  system clock, 6.144 MHz
- RST_N  in  1  synchronous active-low reset
- SPI_EN  in  1  high = configuration in progress; forces IDLE
- FDATA  in  1  bit clock level, 512 kHz, CLK_G-synchronous
- FADC  in  1  frame clock level, 64 kHz, CLK_G-synchronous
- ADC_DOUT  in  NCH  serial data, one bit per channel
- DATA_OUT  out  NCH*BITS  channel c occupies bits [c*BITS +: BITS], MSB first
- DATA_VALID  out  1  holding register full
- DATA_READY  in  1  consumer accepts when DATA_VALID && DATA_READY
- FRAME_ERR  out  1  1-cycle pulse: frame closed with bit count != BITS
- OVERRUN  out  1  1-cycle pulse: good frame completed while holding register full

Behaviour:
- Edge detect: FDATA and FADC are registered once more. fdata_rise = FDATA & !fdata_d; fadc_rise likewise. Detection latency is 1 CLK_G.
- Reset (RST_N = 0 at a CLK_G posedge): state = IDLE; shift registers, bit counter, DATA_OUT, DATA_VALID, FRAME_ERR and OVERRUN all 0; edge-detect registers 0.
- SPI_EN = 1 acts as a synchronous soft reset of everything except DATA_OUT/DATA_VALID, which hold so that a pending word can still drain.
- State IDLE: go to ALIGN when SPI_EN = 0.
- State ALIGN: ignore fdata_rise until the first fadc_rise, then go to RUN. A coincident fdata_rise in that cycle captures bit 0 of the first frame and sets count = 1.
- State RUN:
  - fdata_rise alone: shift[c] <= {shift[c][BITS-2:0], ADC_DOUT[c]}; count++. count saturates at 2^CNT_W-1.
  - fadc_rise: close the frame. If count == BITS it is a good frame. Otherwise pulse FRAME_ERR, discard the frame, and stay in RUN.
  - fadc_rise and fdata_rise in the same cycle: close the old frame with its current count, then capture the current bit as the first bit of the new frame (count = 1).
- Good frame with holding register empty, or emptied in that same cycle by a handshake: DATA_OUT <= shift contents; DATA_VALID = 1 on the next cycle. Latency from the closing fadc_rise detection to DATA_VALID is 1 CLK_G.
- Good frame with holding register full and no handshake: pulse OVERRUN, drop the new frame, keep the old word.
- Handshake: when DATA_VALID && DATA_READY, DATA_VALID clears next cycle unless a new word loads in the same cycle, in which case it stays 1 with the new data.
- DATA_OUT is stable while DATA_VALID = 1 and not accepted.
- Nominal timing: 12 CLK_G per FDATA period, 96 CLK_G per frame. The block tolerates any period, provided consecutive edge events are ≥2 CLK_G apart.

Optional Feature:
- Macro ADC_DESER_FRAME_CNT_EN.
- Defined: adds output FRAME_CNT (16 bits). Its internal counter increments on every closed frame, good or bad, and wraps 0xFFFF -> 0. It resets to 0 on RST_N and on SPI_EN. FRAME_CNT is latched alongside DATA_OUT, so the consumer can detect dropped or errored frames from gaps.
- Undefined: no port and no counter logic.

Decomposition:
- Package adc_deser_pkg: state enum (IDLE, ALIGN, RUN); default NCH/BITS; nominal constants FDATA_DIV = 12 and FRAME_DIV = 8 for benches.
- One sub-module, edge_det_sync: registered rising-edge detector with synchronous reset, instantiated for FDATA and FADC.

Test Plan:
- Nominal stream, NCH = 4, BITS = 8, DATA_READY = 1. Drive patterns 0xA5, 0x3C, 0xFF, 0x01 MSB first -> after the 2nd fadc_rise, DATA_OUT = 0x01FF3CA5 and DATA_VALID pulses 1 cycle, once per 96 CLK_G.
- Reset and alignment: release RST_N mid-frame -> no DATA_VALID until one full frame after the first fadc_rise. All outputs are 0 while RST_N = 0.
- Short frame: suppress 1 FDATA edge (7 bits) -> FRAME_ERR pulses once, no DATA_VALID. The next nominal frame is delivered correctly.
- Backpressure: hold DATA_READY = 0 across 2 good frames -> first word held, OVERRUN pulses once. Raise READY -> first word accepted, DATA_VALID drops the next cycle.
- SPI_EN asserted mid-frame for 50 cycles -> partial frame discarded, pending word still drains. Re-ALIGN: the first word after SPI_EN falls is a complete frame.
- With ADC_DESER_FRAME_CNT_EN: sequence good, bad, good -> delivered FRAME_CNT values are 1, then 3.
